wht_stream: RTL
===============

# wht_stream

Parametrised streaming Walsh-Hadamard transform engine, the successor to the fixed 64-point, all-parallel DWT processor. It accepts one signed sample per handshake, buffers a frame of N samples, and computes the transform iteratively, one butterfly stage per cycle. It then streams N results out with backpressure. It sits between a sample source and any downstream consumer that uses a valid/ready handshake.

## Interface
- N, 64: points per frame; power of two, 4..256.
- DW, 16: input sample width, signed two's complement.
- OW, DW+$clog2(N): output width, signed; derived, never overridden.
- iCLK  in  1  clock; all logic on rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iVALID  in  1  input sample valid.
- oREADY  out  1  block can accept an input sample.
- iDATA  in  DW  input sample.
- oVALID  out  1  output sample valid.
- iREADY  in  1  downstream can accept an output sample.
- oDATA  out  OW  transform coefficient.
- oLAST  out  1  marks coefficient N-1 of the frame.
- oBUSY  out  1  high in COMPUTE and UNLOAD.

## Operation
- States:
  - LOAD: fill the frame buffer. Input handshake is iVALID&oREADY; sample k (k=0..N-1) is sign-extended to OW and written to buf[k]. After the N-th handshake, go to COMPUTE.
  - COMPUTE: stage counter s=0..LOG2N-1. Each cycle applies every butterfly of stage s in parallel: for i with bit s of i clear and h=2^s, buf[i]<=buf[i]+buf[i+h] and buf[i+h]<=buf[i]-buf[i+h]. After s=LOG2N-1, go to UNLOAD.
  - UNLOAD: output index k=0..N-1. oDATA=buf[map(k)]. Output handshake is oVALID&iREADY. After the handshake of k=N-1, go to LOAD.
- Result is natural (Hadamard) order: out[k]=sum_n x[n]*(-1)^popcount(n&k).
- Arithmetic: OW bits is exact. |out| ≤ N*2^(DW-1), so there is no overflow and no saturation.
- oREADY=1 only in LOAD. Input while not in LOAD is ignored and is not queued.
- Backpressure: while iREADY=0, oVALID stays high and oDATA and oLAST are held stable.

## Timing
- Reset values: state=LOAD, counters=0, oVALID=0, oLAST=0, oBUSY=0, oDATA=0. oREADY=1 in the first cycle after reset deasserts. Buffer contents are don't-care.
- Last input accepted at edge t: the COMPUTE stages occupy the edges t+1..t+LOG2N. oVALID rises in the cycle after edge t+LOG2N.
- Frame period with no stalls: N + LOG2N + N cycles.
- After the handshake of k=N-1, oVALID=0 and oREADY=1 from the next cycle. There are no overlapping frames.
- Stalls on iVALID or iREADY extend the frame by exactly the stall cycles.
- Reset mid-frame, in any state, discards the partial frame. No further outputs are issued from it.

## Configuration
- WHT_SEQ_ORDER_EN defined: output in sequency (Walsh) order. map(k)=bitrev_LOG2N(k^(k>>1)).
- Undefined: natural order, map(k)=k.
- Latency and handshake are identical in both builds; only the read index changes.

## Structure
- wht_pkg:
  - state enum {LOAD, COMPUTE, UNLOAD};
  - function gray(k);
  - function bitrev(k, bits);
  - the derived-width rule for OW.
- Sub-module wht_stage: combinational single butterfly stage over the N-entry buffer, with runtime stage select s. The top module holds the FSM, counters, buffer and output mux.

## Test plan
- N=4, DW=16, natural build; input 1,2,3,4; downstream always ready -> outputs 10,-2,-4,0; oLAST with the 0. oVALID rises exactly 2 cycles after the last input handshake.
- Same stimulus, WHT_SEQ_ORDER_EN build -> outputs 10,-4,0,-2.
- N=64, DW=16, ramp 0..63, natural build -> out[0]=2016, out[1]=-32, out[2]=-64, out[4]=-128, …, out[32]=-1024, all other outputs 0. In the sequency build: out[0]=2016, out[1]=-1024, out[63]=-32.
- N=64, all inputs -32768 -> out[0]=-2097152 (the OW=22 minimum, no wrap), all other outputs 0. All inputs +32767 -> out[0]=2097088.
- Random iREADY toggling (50%) and iVALID gaps over 3 back-to-back frames -> outputs match a software model. oDATA and oLAST are stable during stalls, and oREADY=0 throughout COMPUTE and UNLOAD.
- Assert iRST for 1 cycle mid-LOAD (after 30 samples) and again mid-UNLOAD (after 10 outputs) -> oVALID=0 and oREADY=1 the next cycle. The following full frame is transformed correctly, with no residue from the aborted frame.

Source files
------------

// File: rtl/wht_pkg.sv
// Shared types and helpers for the streaming Walsh-Hadamard transform.
package wht_pkg;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    UNLOAD
  } state_e;

  // Widest frame supported is 256 points, so indices never exceed 8 bits.
  localparam int unsigned MAX_LOG2N = 8;

  // Output width: each of the log2(N) stages can grow the magnitude by one bit.
  function automatic int unsigned ow_width(input int unsigned n, input int unsigned dw);
    return dw + $clog2(n);
  endfunction

  function automatic logic [MAX_LOG2N-1:0] gray(input logic [MAX_LOG2N-1:0] k);
    return k ^ (k >> 1);
  endfunction

  // Reverse the low 'bits' bits of k; bits above that are returned as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] k,
                                                  input int unsigned bits);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < bits; i++) begin
      r[i] = k[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/wht_stream_if.sv
// Input/output stream handshake bundle for wht_stream.
// slave: the transform engine side; master: source/sink side.
interface wht_stream_if #(
  parameter int unsigned N  = 64,
  parameter int unsigned DW = 16
);
  import wht_pkg::*;

  localparam int unsigned OW = ow_width(N, DW);

  logic                 iVALID;
  logic                 oREADY;
  logic signed [DW-1:0] iDATA;
  logic                 oVALID;
  logic                 iREADY;
  logic signed [OW-1:0] oDATA;
  logic                 oLAST;
  logic                 oBUSY;

  modport slave (
    input  iVALID, iDATA, iREADY,
    output oREADY, oVALID, oDATA, oLAST, oBUSY
  );

  modport master (
    output iVALID, iDATA, iREADY,
    input  oREADY, oVALID, oDATA, oLAST, oBUSY
  );

endinterface

// File: rtl/wht_stage.sv
// One radix-2 butterfly stage across the whole N-entry buffer.
// Stage s pairs entries i and i+2^s (bit s of i clear); fully combinational.
module wht_stage #(
  parameter int unsigned N  = 64,
  parameter int unsigned OW = 22
) (
  input  logic [$clog2(N)-1:0] s,
  input  logic signed [OW-1:0] buf_i [N],
  output logic signed [OW-1:0] buf_o [N]
);
  localparam int unsigned LOG2N = $clog2(N);

  logic [LOG2N-1:0] h;

  // Sum into the lower partner, difference into the upper partner.
  always_comb begin
    h = LOG2N'(1) << s;
    for (int unsigned i = 0; i < N; i++) begin
      if ((LOG2N'(i) & h) == '0) begin
        buf_o[i] = buf_i[i] + buf_i[LOG2N'(i) | h];
      end else begin
        buf_o[i] = buf_i[LOG2N'(i) ^ h] - buf_i[i];
      end
    end
  end

endmodule

// File: rtl/wht_stream.sv
// Streaming Walsh-Hadamard transform: load N samples, run log2(N) in-place
// butterfly stages (one per cycle), then stream N coefficients out.
// Build option WHT_SEQ_ORDER_EN: emit coefficients in sequency (Walsh) order
// instead of natural (Hadamard) order; timing is unchanged.
module wht_stream
  import wht_pkg::*;
#(
  parameter int unsigned N  = 64,
  parameter int unsigned DW = 16
) (
  input logic       iCLK,
  input logic       iRST,
  wht_stream_if.slave io
);
  localparam int unsigned     LOG2N    = $clog2(N);
  localparam int unsigned     OW       = ow_width(N, DW);
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] STG_LAST = LOG2N'(LOG2N - 1);

  state_e              state_q, state_d;
  // One counter serves as sample index, stage index and output index.
  logic [LOG2N-1:0]    cnt_q, cnt_d;
  logic signed [OW-1:0] buf_q [N];
  logic signed [OW-1:0] buf_d [N];
  logic signed [OW-1:0] stage_out [N];
  logic                in_hs;
  logic                out_hs;
  logic [LOG2N-1:0]    rd_idx;

  wht_stage #(.N(N), .OW(OW)) u_stage (
    .s     (cnt_q),
    .buf_i (buf_q),
    .buf_o (stage_out)
  );

  assign in_hs  = io.iVALID && (state_q == LOAD);
  assign out_hs = io.iREADY && (state_q == UNLOAD);

  // State and counter registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame buffer; contents are don't-care after reset.
  always_ff @(posedge iCLK) begin
    buf_q <= buf_d;
  end

  // Next state and counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOAD: begin
        if (in_hs) begin
          if (cnt_q == CNT_LAST) begin
            state_d = COMPUTE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end
      COMPUTE: begin
        if (cnt_q == STG_LAST) begin
          state_d = UNLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LOG2N'(1);
        end
      end
      UNLOAD: begin
        if (out_hs) begin
          if (cnt_q == CNT_LAST) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Buffer update: sign-extended sample write while loading, stage result while computing.
  always_comb begin
    buf_d = buf_q;
    if (in_hs) begin
      buf_d[cnt_q] = {{(OW-DW){io.iDATA[DW-1]}}, io.iDATA};
    end
    if (state_q == COMPUTE) begin
      buf_d = stage_out;
    end
  end

  // Read index: sequency order maps k through Gray code then bit reversal.
  always_comb begin
`ifdef WHT_SEQ_ORDER_EN
    rd_idx = LOG2N'(bitrev(gray(MAX_LOG2N'(cnt_q)), LOG2N));
`else
    rd_idx = cnt_q;
`endif
  end

  // Handshake and data outputs, decoded from state.
  always_comb begin
    io.oREADY = (state_q == LOAD);
    io.oVALID = (state_q == UNLOAD);
    io.oBUSY  = (state_q != LOAD);
    io.oLAST  = (state_q == UNLOAD) && (cnt_q == CNT_LAST);
    io.oDATA  = (state_q == UNLOAD) ? buf_q[rd_idx] : '0;
  end

endmodule
